// File: rtl/sram_burst_pkg.sv
// Shared types and helpers for the SRAM burst master.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Address increment with an explicit wrap, so DEPTH need not be a power of 2.
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/sram_burst_rd_buf.sv
// Two-entry valid/ready FIFO holding SRAM read data; count feeds the read-issue gate.
module sram_burst_rd_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop   = (r_count != 2'd0) && i_pop_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port SRAM with a 1-cycle registered read;
// read latency is hidden behind a 2-entry buffer so the consumer may stall freely.
module sram_burst_master
  import sram_burst_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW-1:0]    cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_left;
  logic            r_inflight;
  logic            r_busy;
  logic            r_done;
  logic [1:0]      w_count;
  logic            w_issue;
  logic            w_wbeat;
  logic            w_cmd_hs;
  logic [AW-1:0]   w_addr_nxt;

  assign w_cmd_hs   = (r_state == ST_IDLE) && cmd_valid;
  assign w_wbeat    = (r_state == ST_WRITE) && wr_valid;
  // Buffered plus in-flight words never exceed the two buffer slots.
  assign w_issue    = (r_state == ST_READ) &&
                      (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2);
  assign w_addr_nxt = AW'(next_addr(32'(r_addr), unsigned'(DEPTH)));

  assign cmd_ready = (r_state == ST_IDLE);
  assign wr_ready  = (r_state == ST_WRITE);
  assign mem_we    = w_wbeat;
  assign mem_addr  = r_addr;
  assign mem_wdata = wr_data;
  assign busy      = r_busy;
  assign done      = r_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_state_nxt = cmd_we ? ST_WRITE : ST_READ;
      ST_WRITE: if (wr_valid && (r_left == '0)) w_state_nxt = ST_IDLE;
      ST_READ:  if (w_issue && (r_left == '0)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_inflight) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_left     <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
      r_inflight <= w_issue;
      if (w_cmd_hs) begin
        r_addr <= cmd_addr;
        r_left <= cmd_len;
      end else if (w_wbeat || w_issue) begin
        r_addr <= w_addr_nxt;
        r_left <= r_left - AW'(1);
      end
    end
  end

  sram_burst_rd_buf #(
    .WIDTH (WIDTH)
  ) u_rd_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (mem_rdata),
    .i_pop_ready (rd_ready),
    .o_valid     (rd_valid),
    .o_data      (rd_data),
    .o_count     (w_count)
  );

endmodule

// File: tb/tb_sram_burst_master.sv
// Scoreboard bench for sram_burst_master driving a behavioural single-port SRAM.
module tb_sram_burst_master;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_we = 1'b0;
  logic [AW-1:0]    cmd_addr = '0;
  logic [AW-1:0]    cmd_len = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b1;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic [WIDTH-1:0] sram   [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic [AW-1:0]    wq_addr [$];
  logic [WIDTH-1:0] wq_data [$];
  logic [WIDTH-1:0] rq_data [$];

  always #5 clk = ~clk;

  sram_burst_master #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port SRAM: registered read, output held during writes.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    else        mem_rdata      <= sram[mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (wq_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        chk("wr_addr", 64'(mem_addr), 64'(wq_addr.pop_front()));
        chk("wr_data", 64'(mem_wdata), 64'(wq_data.pop_front()));
      end
    end
  end

  // Read monitor
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (rq_data.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got %0h expected no beat", rd_data);
      end else begin
        chk("rd_data", 64'(rd_data), 64'(rq_data.pop_front()));
      end
    end
  end

  always @(negedge clk) if (rst_n && done) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int n;
    logic [AW-1:0] a;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    if (!we) begin
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
        rq_data.push_back(shadow[a]);
        a = inc(a);
      end
    end
    tick();
    cmd_valid = 1'b0;
    chk("busy_after_cmd", 64'(busy), 64'd1);
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic finish_burst(input int done_base);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("busy_falls", 64'(busy), 64'd0);
    tick();
    tick();
    chk("done_count", 64'(done_cnt), 64'(done_base + 1));
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                             input logic [WIDTH-1:0] base, input bit gaps);
    int db;
    logic [AW-1:0] a;
    db = done_cnt;
    do_cmd(1'b1, addr, len);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && (i % 2 == 1)) begin
        wr_valid = 1'b0;
        tick();
        tick();
      end
      if (i == int'(len)) chk("no_early_done", 64'(done_cnt), 64'(db));
      chk("wr_ready", 64'(wr_ready), 64'd1);
      wr_valid = 1'b1;
      wr_data  = base + WIDTH'(i);
      wq_addr.push_back(a);
      wq_data.push_back(base + WIDTH'(i));
      shadow[a] = base + WIDTH'(i);
      a = inc(a);
      tick();
    end
    wr_valid = 1'b0;
    finish_burst(db);
    chk("wq_empty", 64'(wq_addr.size()), 64'd0);
  endtask

  task automatic drain_reads(input bit toggle, input int done_base);
    int c;
    c = 0;
    while ((rq_data.size() != 0 || busy) && c < 300) begin
      rd_ready = toggle ? (c % 3 == 0) : 1'b1;
      tick();
      c++;
    end
    rd_ready = 1'b1;
    chk("rq_empty", 64'(rq_data.size()), 64'd0);
    finish_burst(done_base);
    chk("rd_valid_idle", 64'(rd_valid), 64'd0);
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int db;
    db = done_cnt;
    rd_ready = 1'b1;
    do_cmd(1'b0, addr, len);
    drain_reads(1'b0, db);
  endtask

  initial begin
    int db;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    #12;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic burst at addr 2
    write_burst(3'd2, 3'd3, 32'hA000_0000, 1'b0);
    read_burst(3'd2, 3'd3);

    // Wrap 6,7,0,1
    write_burst(3'd6, 3'd3, 32'hB000_0000, 1'b0);
    read_burst(3'd6, 3'd3);

    // Write with wr_valid gaps
    write_burst(3'd0, 3'd3, 32'hC000_0000, 1'b1);

    // Single beat at addr 7
    write_burst(3'd7, 3'd0, 32'hD000_0000, 1'b0);
    read_burst(3'd7, 3'd0);

    // Backpressure: full-depth read, stall then toggle rd_ready
    db = done_cnt;
    rd_ready = 1'b0;
    do_cmd(1'b0, 3'd0, 3'd7);
    repeat (6) tick();
    chk("stall_issue_addr", 64'(mem_addr), 64'd2);
    chk("stall_rd_valid", 64'(rd_valid), 64'd1);
    chk("stall_busy", 64'(busy), 64'd1);
    drain_reads(1'b1, db);

    // Reset in the middle of a read
    db = done_cnt;
    rd_ready = 1'b0;
    do_cmd(1'b0, 3'd0, 3'd7);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rd_valid", 64'(rd_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    rq_data.delete();
    tick();
    rst_n = 1'b1;
    rd_ready = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(db));
    read_burst(3'd4, 3'd1);
    read_burst(3'd0, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
